// File: rtl/nn_pkg.sv
// Shared constants, FSM state type and width helper for the neural-net output stages.
// Sized for the 10-class digit classifier with 8.18 signed fixed-point scores.
package nn_pkg;

    localparam int SCORE_WIDTH = 26;
    localparam int NUM_NEURONS = 10;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int CLASS_WIDTH = clog2_min1(NUM_NEURONS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/argmax_classifier_if.sv
// Score-in / class-out handshake bundle between the output layer and the argmax stage.
// master drives scores and takes the result; slave is the argmax block.
interface argmax_classifier_if #(
    parameter int NUM_NEURONS = nn_pkg::NUM_NEURONS,
    parameter int SCORE_WIDTH = nn_pkg::SCORE_WIDTH,
    parameter int CLASS_WIDTH = nn_pkg::clog2_min1(NUM_NEURONS)
);
    logic [NUM_NEURONS*SCORE_WIDTH-1:0] SCORES;
    logic                               in_valid;
    logic                               in_ready;
    logic                               abort;
    logic [CLASS_WIDTH-1:0]             CLASS;
    logic [SCORE_WIDTH-1:0]             MAX_SCORE;
    logic                               out_valid;
    logic                               out_ready;

    modport master (
        output SCORES, in_valid, abort, out_ready,
        input  in_ready, CLASS, MAX_SCORE, out_valid
    );

    modport slave (
        input  SCORES, in_valid, abort, out_ready,
        output in_ready, CLASS, MAX_SCORE, out_valid
    );
endinterface

// File: rtl/signed_max_cmp.sv
// Purpose: signed greater-than of two equal-width two's complement values.
// Latency: combinational. Backpressure: none (no handshake).
module signed_max_cmp #(
    parameter int WIDTH = nn_pkg::SCORE_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b
);
    assign a_gt_b = $signed(a) > $signed(b);
endmodule

// File: rtl/argmax_classifier.sv
// Purpose: index and value of the largest signed score, scanned one score per cycle.
// Latency: out_valid after capture edge + NUM_NEURONS-1. Backpressure: result held until out_ready; in_ready only in IDLE.
module argmax_classifier #(
    parameter int NUM_NEURONS = nn_pkg::NUM_NEURONS,
    parameter int SCORE_WIDTH = nn_pkg::SCORE_WIDTH,
    parameter int CLASS_WIDTH = nn_pkg::clog2_min1(NUM_NEURONS)
) (
    input  logic              clk,
    input  logic              rst,
    argmax_classifier_if.slave io
);
    import nn_pkg::*;

    state_t                 state;
    state_t                 state_nxt;
    logic [SCORE_WIDTH-1:0] score_q [NUM_NEURONS];
    logic [SCORE_WIDTH-1:0] best_q;
    logic [SCORE_WIDTH-1:0] cur_score;
    logic [CLASS_WIDTH-1:0] cnt_q;
    logic [CLASS_WIDTH-1:0] idx_q;
    logic                   cur_gt;
    logic                   fire_in;
    logic                   last_cnt;

    assign fire_in   = io.in_valid && (state == IDLE);
    assign last_cnt  = (cnt_q == CLASS_WIDTH'(NUM_NEURONS - 1));
    assign cur_score = score_q[cnt_q];

    signed_max_cmp #(.WIDTH(SCORE_WIDTH)) u_cmp (
        .a      (cur_score),
        .b      (best_q),
        .a_gt_b (cur_gt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // abort outranks both scan progression and the output handshake
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (io.in_valid) begin
                    state_nxt = (NUM_NEURONS == 1) ? HOLD : SCAN;
                end
            end
            SCAN: begin
                if (io.abort) begin
                    state_nxt = IDLE;
                end else if (last_cnt) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (io.abort || io.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        io.in_ready  = (state == IDLE);
        io.out_valid = (state == HOLD);
        io.CLASS     = idx_q;
        io.MAX_SCORE = best_q;
    end

    // strict > keeps the earlier index on ties
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                score_q[k] <= '0;
            end
            best_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else if (fire_in) begin
            for (int k = 0; k < NUM_NEURONS; k++) begin
                score_q[k] <= io.SCORES[k*SCORE_WIDTH +: SCORE_WIDTH];
            end
            best_q <= io.SCORES[SCORE_WIDTH-1:0];
            idx_q  <= '0;
            cnt_q  <= CLASS_WIDTH'(1);
        end else if (state == SCAN && !io.abort) begin
            if (cur_gt) begin
                best_q <= cur_score;
                idx_q  <= cnt_q;
            end
            cnt_q <= cnt_q + CLASS_WIDTH'(1);
        end
    end

endmodule
